sample_streamer: RTL and testbench

//  Address sequencer and stream source upstream of the filter pipeline.
//  - Drives rom_addr into the registered sample ROM: 1-cycle read latency, async-reset output.
//  - Captures the returned rom_data into a small FIFO.
//  - Presents samples as a valid/ready stream with frame-end marking to the filter input stage.

---
 rtl/sample_streamer.sv | 103 ++++++++++
 tb/tb_sample_streamer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_streamer.sv
// Sample ROM address sequencer feeding a first-word-fall-through FIFO that sources a valid/ready stream.
// Define SAMPLE_STREAM_LOOP_EN to stream frames back-to-back until stop.
module sample_streamer #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int NUM_SAMPLES = 1024,
  parameter int BUF_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W:0]   fifo_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [CNT_W:0]    credit_use;
  logic              vld_p1, last_p1;
  logic              pop, issue, last_exit, drained, done_nxt;
  logic [DATA_W:0]   head;

  assign head    = fifo_mem[rd_ptr];
  assign m_valid = (count != '0);
  assign m_data  = m_valid ? head[DATA_W-1:0] : '0;
  assign m_last  = m_valid & head[DATA_W];
  assign busy    = (state != IDLE);
  assign pop     = m_valid & m_ready;

  // Slots already committed (held + in flight), crediting a same-cycle pop
  assign credit_use = (CNT_W+1)'(count) + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
  assign issue      = (state == RUN) && !stop && (credit_use < (CNT_W+1)'(BUF_DEPTH));
  assign count_nxt  = count + CNT_W'(vld_p1) - CNT_W'(pop);
  assign drained    = !vld_p1 && (count_nxt == '0);

`ifdef SAMPLE_STREAM_LOOP_EN
  assign last_exit = 1'b0;
`else
  assign last_exit = issue && (rom_addr == LAST_ADDR);
`endif

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop || last_exit) state_nxt = DRAIN;
      DRAIN: begin
        if (drained) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: address issue and control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      vld_p1   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      done     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done   <= done_nxt;
      vld_p1 <= issue;
      count  <= count_nxt;
      if (vld_p1) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      if (state == IDLE && start)
        rom_addr <= '0;
      else if (issue)
        rom_addr <= (rom_addr == LAST_ADDR) ? '0 : rom_addr + ADDR_W'(1);
    end
  end

  // Stage p1: ROM data returns and is captured with its frame-end tag
  always_ff @(posedge clk) begin
    last_p1 <= issue && (rom_addr == LAST_ADDR);
    if (vld_p1) fifo_mem[wr_ptr] <= {last_p1, rom_data};
  end

endmodule

// File: tb/tb_sample_streamer.sv
// Bench for sample_streamer: registered ROM model, stream monitor and frame scoreboard.
// Build with SAMPLE_STREAM_LOOP_EN defined to exercise the looping configuration.
module tb_sample_streamer;

`ifdef SAMPLE_STREAM_LOOP_EN
  localparam int NS = 8;
`else
  localparam int NS = 1024;
`endif
  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int BUF = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] rom_mem [NS];
  logic [DW:0]   got_q [$];
  int            xfer_cyc [$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            issued = 0, delivered = 0, out_bad = 0, stall_bad = 0;
  logic [AW-1:0] prev_addr = '0;
  logic          have_stall = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  sample_streamer #(.ADDR_W(AW), .DATA_W(DW), .NUM_SAMPLES(NS), .BUF_DEPTH(BUF)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .rom_addr(rom_addr),
    .rom_data(rom_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset)
    if (reset) rom_data <= '0;
    else       rom_data <= rom_mem[rom_addr];

  // Monitor: collects transfers, watches stall stability and outstanding reads
  always @(negedge clk) begin
    if (reset) begin
      have_stall = 1'b0;
      prev_addr  = rom_addr;
    end else begin
      if (rom_addr !== prev_addr) issued++;
      prev_addr = rom_addr;
      if (issued - delivered > BUF) out_bad++;
      if (have_stall && !(m_valid === 1'b1 && m_data === stall_data && m_last === stall_last))
        stall_bad++;
      have_stall = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        got_q.push_back({m_last, m_data});
        xfer_cyc.push_back(cyc);
        delivered++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mismatches between collected stream from index base and the ideal frame sequence
  function automatic int frame_bad(input int base, input int n);
    int bad = 0;
    logic [DW:0] e;
    for (int k = 0; k < n; k++) begin
      e = {((k % NS) == NS - 1), rom_mem[k % NS]};
      if (base + k >= got_q.size()) bad++;
      else if (got_q[base + k] !== e) bad++;
    end
    return bad;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int base, bad, n, ob0;

    for (int i = 0; i < NS; i++) rom_mem[i] = DW'(i);
    repeat (3) @(negedge clk);
    check("rst_addr",  32'(rom_addr), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data",  32'(m_data), 0);
    check("rst_last",  32'(m_last), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    @(posedge clk); #1 reset = 1'b0;

`ifndef SAMPLE_STREAM_LOOP_EN
    // T1: full frame, ready held high
    m_ready = 1'b1;
    base = got_q.size();
    pulse_start();
    @(negedge clk);
    check("t1_busy", 32'(busy), 1);
    check("t1_valid_s1", 32'(m_valid), 0);
    @(negedge clk);
    check("t1_valid_s2", 32'(m_valid), 0);
    @(negedge clk);
    check("t1_valid_s3", 32'(m_valid), 1);
    bad = 0;
    for (int i = 0; i < NS; i++) begin
      if (!(m_valid === 1'b1 && m_data === rom_mem[i] && m_last === (i == NS - 1))) bad++;
      @(negedge clk);
    end
    check("t1_stream", 32'(bad), 0);
    check("t1_done", 32'(done), 1);
    check("t1_busy_end", 32'(busy), 0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 0);
    check("t1_outstanding", 32'(out_bad), 0);

    // T2: random ROM contents, random 50% ready
    for (int i = 0; i < NS; i++) rom_mem[i] = DW'($urandom);
    base = got_q.size();
    ob0 = out_bad;
    pulse_start();
    n = 0;
    while (done !== 1'b1 && n < 8000) begin
      @(posedge clk); #1 m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    check("t2_done", 32'(done), 1);
    check("t2_count", 32'(got_q.size() - base), NS);
    check("t2_data", 32'(frame_bad(base, NS)), 0);
    check("t2_stall_stable", 32'(stall_bad), 0);
    check("t2_outstanding", 32'(out_bad - ob0), 0);

    // T3: downstream blocked; start while busy is ignored
    @(posedge clk); #1 m_ready = 1'b0;
    base = got_q.size();
    pulse_start();
    repeat (20) @(negedge clk);
    check("t3_addr", 32'(rom_addr), 4);
    check("t3_valid", 32'(m_valid), 1);
    check("t3_head", 32'(m_data), 32'(rom_mem[0]));
    check("t3_none", 32'(got_q.size() - base), 0);
    pulse_start();
    repeat (2) @(negedge clk);
    check("t3_addr_hold", 32'(rom_addr), 4);
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    wait_done("t3", 3000);
    check("t3_count", 32'(got_q.size() - base), NS);
    check("t3_data", 32'(frame_bad(base, NS)), 0);
    check("t3_gapless", 32'(xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[base]), NS - 1);

    // T4: stop while address 100 is presented
    base = got_q.size();
    pulse_start();
    n = 0;
    while (rom_addr !== AW'(100) && n < 500) begin
      @(negedge clk);
      n++;
    end
    stop = 1'b1;
    wait_done("t4", 100);
    check("t4_count", 32'(got_q.size() - base), 100);
    check("t4_data", 32'(frame_bad(base, 100)), 0);
    @(negedge clk);
    stop = 1'b0;
    check("t4_idle", 32'(busy), 0);

    // T5: reset mid-frame, then a fresh frame from sample 0
    pulse_start();
    base = got_q.size();
    n = 0;
    while (got_q.size() - base < 500 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("t5_valid", 32'(m_valid), 0);
    check("t5_addr", 32'(rom_addr), 0);
    check("t5_busy", 32'(busy), 0);
    @(posedge clk); #1 reset = 1'b0;
    base = got_q.size();
    pulse_start();
    @(negedge clk);
    wait_done("t5", 3000);
    check("t5_count", 32'(got_q.size() - base), NS);
    check("t5_data", 32'(frame_bad(base, NS)), 0);
`else
    // T6: looping frames until stop
    m_ready = 1'b1;
    base = got_q.size();
    pulse_start();
    n = 0;
    while (got_q.size() - base < 3 * NS && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_busy_run", 32'(busy), 1);
    stop = 1'b1;
    wait_done("t6", 100);
    check("t6_count_min", 32'(got_q.size() - base >= 3 * NS), 1);
    check("t6_count_max", 32'(got_q.size() - base <= 3 * NS + BUF), 1);
    check("t6_data", 32'(frame_bad(base, got_q.size() - base)), 0);
    @(negedge clk);
    check("t6_done_pulse", 32'(done), 0);
    stop = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
